// File: rtl/dcpu16_arb_pkg.sv
// rtl/dcpu16_arb_pkg.sv - shared encodings and defaults for the dcpu16 bus arbiter
//
// Purpose: owner and state encodings used by the arbiter top and its
// round-robin picker, plus the default watchdog limit.
// Ports: none (package).
package dcpu16_arb_pkg;

  // Owner encoding doubles as the externally visible gnt value.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_G    = 2'd2,
    OWN_X    = 2'd3
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int TMO_DEFAULT = 15;
  localparam int WDT_W       = 8;

endpackage

// File: rtl/dcpu16_arb_rr.sv
// rtl/dcpu16_arb_rr.sv - combinational three-way round-robin picker
//
// Purpose: choose the next owner among f/g/x, searching in the order that
// starts just after the last owner.
// Ports:
//   i_req  [2:0] request vector, bit0 = f, bit1 = g, bit2 = x
//   i_last       last owner (OWN_NONE is treated like OWN_X)
//   o_next       picked owner, OWN_NONE when no request is present
module dcpu16_arb_rr
  import dcpu16_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  owner_e     i_last,
  output owner_e     o_next
);

  always_comb begin
    o_next = OWN_NONE;
    case (i_last)
      OWN_F: begin
        if      (i_req[1]) o_next = OWN_G;
        else if (i_req[2]) o_next = OWN_X;
        else if (i_req[0]) o_next = OWN_F;
      end
      OWN_G: begin
        if      (i_req[2]) o_next = OWN_X;
        else if (i_req[0]) o_next = OWN_F;
        else if (i_req[1]) o_next = OWN_G;
      end
      default: begin
        if      (i_req[0]) o_next = OWN_F;
        else if (i_req[1]) o_next = OWN_G;
        else if (i_req[2]) o_next = OWN_X;
      end
    endcase
  end

endmodule

// File: rtl/dcpu16_arb.sv
// rtl/dcpu16_arb.sv - round-robin arbiter sharing one memory slave among f, g and x buses
//
// Purpose: grant one stb/wre/adr/dat/ack transaction at a time to the CPU
// fetch bus (f), CPU data bus (g) or external bus (x), with a watchdog that
// force-completes transactions the slave never acknowledges.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   {f,g,x}_stb/wre/adr/dto   requester strobe, write enable, address, write data
//   {f,g,x}_dti/ack           read data and done pulse back to requesters
//   m_stb/wre/adr/dto         slave request side
//   m_dti/ack                 slave read data and acknowledge
//   err                       one-cycle watchdog-fired pulse
//   gnt                       current owner (0 none, 1 f, 2 g, 3 x)
module dcpu16_arb
  import dcpu16_arb_pkg::*;
#(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_stb,
  input  logic          f_wre,
  input  logic [AW-1:0] f_adr,
  input  logic [DW-1:0] f_dto,
  output logic [DW-1:0] f_dti,
  output logic          f_ack,
  input  logic          g_stb,
  input  logic          g_wre,
  input  logic [AW-1:0] g_adr,
  input  logic [DW-1:0] g_dto,
  output logic [DW-1:0] g_dti,
  output logic          g_ack,
  input  logic          x_stb,
  input  logic          x_wre,
  input  logic [AW-1:0] x_adr,
  input  logic [DW-1:0] x_dto,
  output logic [DW-1:0] x_dti,
  output logic          x_ack,
  output logic          m_stb,
  output logic          m_wre,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_dto,
  input  logic [DW-1:0] m_dti,
  input  logic          m_ack,
  output logic          err,
  output logic [1:0]    gnt
);

  // Counter holds (cycles of m_stb so far); it expires in the TMO-th cycle.
  localparam logic [WDT_W-1:0] TMO_LIM = WDT_W'(TMO - 1);

  state_e             r_state, w_state_nxt;
  owner_e             r_gnt, w_gnt_nxt;
  owner_e             r_last, w_last_nxt;
  logic [WDT_W-1:0]   r_wdt, w_wdt_nxt;

  logic [2:0]         w_req;
  owner_e             w_pick;
  logic               w_busy;
  logic               w_own_stb;
  logic               w_own_wre;
  logic [AW-1:0]      w_own_adr;
  logic [DW-1:0]      w_own_dto;
  logic               w_expire;
  logic               w_ack_own;

  assign w_req  = {x_stb, g_stb, f_stb};
  assign w_busy = (r_state == ST_BUSY);

  dcpu16_arb_rr u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_next (w_pick)
  );

  // Owner-side request mux; r_gnt is OWN_NONE whenever the arbiter is idle.
  always_comb begin
    w_own_stb = 1'b0;
    w_own_wre = 1'b0;
    w_own_adr = '0;
    w_own_dto = '0;
    case (r_gnt)
      OWN_F: begin
        w_own_stb = f_stb; w_own_wre = f_wre; w_own_adr = f_adr; w_own_dto = f_dto;
      end
      OWN_G: begin
        w_own_stb = g_stb; w_own_wre = g_wre; w_own_adr = g_adr; w_own_dto = g_dto;
      end
      OWN_X: begin
        w_own_stb = x_stb; w_own_wre = x_wre; w_own_adr = x_adr; w_own_dto = x_dto;
      end
      default: ;
    endcase
  end

  // A slave ack landing in the expiry cycle wins: it is a normal completion.
  assign w_expire  = w_busy && w_own_stb && (r_wdt >= TMO_LIM) && !m_ack;
  assign w_ack_own = w_busy && (m_ack || w_expire);

  assign m_stb = w_busy && w_own_stb && !w_expire;
  assign m_wre = w_own_wre;
  assign m_adr = w_own_adr;
  assign m_dto = w_own_dto;

  assign f_ack = w_ack_own && (r_gnt == OWN_F);
  assign g_ack = w_ack_own && (r_gnt == OWN_G);
  assign x_ack = w_ack_own && (r_gnt == OWN_X);

  // Read data fans out to everyone; only a forced completion zeroes the owner's copy.
  assign f_dti = (w_expire && r_gnt == OWN_F) ? '0 : m_dti;
  assign g_dti = (w_expire && r_gnt == OWN_G) ? '0 : m_dti;
  assign x_dti = (w_expire && r_gnt == OWN_X) ? '0 : m_dti;

  assign err = w_expire;
  assign gnt = r_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_wdt_nxt   = r_wdt;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt = ST_BUSY;
          w_gnt_nxt   = w_pick;
          w_wdt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        // Completion, forced completion and abort all release the bus the same way.
        if (m_ack || w_expire || !w_own_stb) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gnt;
          w_gnt_nxt   = OWN_NONE;
          w_wdt_nxt   = '0;
        end else if (r_wdt != {WDT_W{1'b1}}) begin
          w_wdt_nxt = r_wdt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= OWN_NONE;
      r_last  <= OWN_X;
      r_wdt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_wdt   <= w_wdt_nxt;
    end
  end

endmodule

// File: tb/tb_dcpu16_arb.sv
// tb/tb_dcpu16_arb.sv - directed self-checking bench for dcpu16_arb
module tb_dcpu16_arb;

  logic        clk;
  logic        rst;
  logic        f_stb, g_stb, x_stb;
  logic        f_wre, g_wre, x_wre;
  logic [15:0] f_adr, g_adr, x_adr;
  logic [15:0] f_dto, g_dto, x_dto;
  logic [15:0] f_dti, g_dti, x_dti;
  logic        f_ack, g_ack, x_ack;
  logic        m_stb, m_wre;
  logic [15:0] m_adr, m_dto, m_dti;
  logic        m_ack;
  logic        err;
  logic [1:0]  gnt;

  int n_checks = 0;
  int n_errors = 0;

  dcpu16_arb #(.AW(16), .DW(16), .TMO(4)) dut (
    .clk(clk), .rst(rst),
    .f_stb(f_stb), .f_wre(f_wre), .f_adr(f_adr), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
    .g_stb(g_stb), .g_wre(g_wre), .g_adr(g_adr), .g_dto(g_dto), .g_dti(g_dti), .g_ack(g_ack),
    .x_stb(x_stb), .x_wre(x_wre), .x_adr(x_adr), .x_dto(x_dto), .x_dti(x_dti), .x_ack(x_ack),
    .m_stb(m_stb), .m_wre(m_wre), .m_adr(m_adr), .m_dto(m_dto), .m_dti(m_dti), .m_ack(m_ack),
    .err(err), .gnt(gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] rr_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
  logic [2:0] onehot;

  initial begin
    rst = 1'b0;
    f_stb = 0; g_stb = 0; x_stb = 0;
    f_wre = 0; g_wre = 0; x_wre = 0;
    f_adr = '0; g_adr = '0; x_adr = '0;
    f_dto = '0; g_dto = '0; x_dto = '0;
    m_dti = '0; m_ack = 0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_m_stb", m_stb, 0);
    check("rst_acks", {x_ack, g_ack, f_ack}, 0);
    check("rst_err", err, 0);
    rst = 1'b1;

    // Single read from g
    g_stb = 1; g_adr = 16'h0010; #1;
    check("rd_idle_gnt", gnt, 0);
    check("rd_idle_m_stb", m_stb, 0);
    cyc(); #1;
    check("rd_gnt", gnt, 2);
    check("rd_m_stb", m_stb, 1);
    check("rd_m_adr", m_adr, 16'h0010);
    check("rd_no_ack_yet", g_ack, 0);
    cyc(); m_ack = 1; m_dti = 16'hBEEF; #1;
    check("rd_g_ack", g_ack, 1);
    check("rd_g_dti", g_dti, 16'hBEEF);
    check("rd_other_acks", {x_ack, f_ack}, 0);
    check("rd_err", err, 0);
    cyc(); m_ack = 0; g_stb = 0; #1;
    check("rd_release_gnt", gnt, 0);
    check("rd_release_ack", g_ack, 0);

    // Round-robin with all three holding stb from reset
    cyc(); rst = 0; f_stb = 1; g_stb = 1; x_stb = 1; #1;
    check("rr_rst_gnt", gnt, 0);
    cyc(); rst = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_bubble%0d_gnt", k), gnt, 0);
      check($sformatf("rr_bubble%0d_m_stb", k), m_stb, 0);
      cyc(); m_ack = 1; m_dti = 16'h0100 + 16'(k); #1;
      onehot = 3'b001 << (rr_exp[k] - 2'd1);
      check($sformatf("rr_grant%0d", k), gnt, rr_exp[k]);
      check($sformatf("rr_acks%0d", k), {x_ack, g_ack, f_ack}, onehot);
      cyc(); m_ack = 0;
    end
    f_stb = 0; g_stb = 0; x_stb = 0; #1;
    check("rr_end_gnt", gnt, 0);

    // Write pass-through from x
    cyc(); x_stb = 1; x_wre = 1; x_adr = 16'h8000; x_dto = 16'h1234; #1;
    check("wr_idle_gnt", gnt, 0);
    cyc(); #1;
    check("wr_gnt", gnt, 3);
    check("wr_m_stb", m_stb, 1);
    check("wr_m_wre", m_wre, 1);
    check("wr_m_adr", m_adr, 16'h8000);
    check("wr_m_dto", m_dto, 16'h1234);
    check("wr_no_ack_yet", x_ack, 0);
    cyc(); m_ack = 1; #1;
    check("wr_x_ack", x_ack, 1);
    check("wr_other_acks", {g_ack, f_ack}, 0);
    cyc(); m_ack = 0; x_stb = 0; x_wre = 0; #1;
    check("wr_release_gnt", gnt, 0);

    // Watchdog: slave never acks, TMO = 4
    cyc(); f_stb = 1; f_adr = 16'h0042;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("wd_cyc%0d_m_stb", i), m_stb, 1);
      check($sformatf("wd_cyc%0d_ack", i), f_ack, 0);
      check($sformatf("wd_cyc%0d_err", i), err, 0);
      cyc();
    end
    m_dti = 16'hAAAA; #1;
    check("wd_fire_f_ack", f_ack, 1);
    check("wd_fire_f_dti", f_dti, 0);
    check("wd_fire_err", err, 1);
    check("wd_fire_m_stb", m_stb, 0);
    check("wd_fire_g_dti", g_dti, 16'hAAAA);
    cyc(); f_stb = 0; g_stb = 1; g_adr = 16'h0020; m_dti = 16'h0000; #1;
    check("wd_after_gnt", gnt, 0);
    check("wd_after_err", err, 0);
    check("wd_after_f_ack", f_ack, 0);
    cyc(); m_ack = 1; m_dti = 16'h1111; #1;
    check("wd_next_gnt", gnt, 2);
    check("wd_next_g_ack", g_ack, 1);
    check("wd_next_g_dti", g_dti, 16'h1111);
    check("wd_next_err", err, 0);
    cyc(); m_ack = 0; g_stb = 0; #1;
    check("wd_next_release", gnt, 0);

    // Abort: g drops stb before any ack
    cyc(); g_stb = 1;
    cyc(); #1;
    check("ab_gnt", gnt, 2);
    cyc(); g_stb = 0; #1;
    check("ab_m_stb", m_stb, 0);
    check("ab_no_ack", g_ack, 0);
    cyc(); #1;
    check("ab_idle_gnt", gnt, 0);
    check("ab_idle_ack", g_ack, 0);
    // Pointer moved to g on abort, so f beats g next
    f_stb = 1; g_stb = 1;
    cyc(); #1;
    check("ab_ptr_gnt", gnt, 1);
    cyc(); m_ack = 1; #1;
    check("ab_ptr_f_ack", f_ack, 1);
    check("ab_ptr_g_ack", g_ack, 0);
    cyc(); m_ack = 0; f_stb = 0; #1;
    check("ab_ptr_release", gnt, 0);
    cyc(); #1;
    check("ab_g_waited_gnt", gnt, 2);

    // Asynchronous reset mid-BUSY
    rst = 0; #1;
    check("arst_m_stb", m_stb, 0);
    check("arst_gnt", gnt, 0);
    check("arst_g_ack", g_ack, 0);
    g_stb = 0;
    cyc(); rst = 1;

    // Collision: m_ack in the expiry cycle
    f_stb = 1;
    cyc();
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("col_cyc%0d_ack", i), f_ack, 0);
      cyc();
    end
    m_ack = 1; m_dti = 16'h5A5A; #1;
    check("col_f_ack", f_ack, 1);
    check("col_f_dti", f_dti, 16'h5A5A);
    check("col_err", err, 0);
    check("col_m_stb", m_stb, 1);
    cyc(); m_ack = 0; f_stb = 0; #1;
    check("col_release_gnt", gnt, 0);
    check("col_release_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
